// File: rtl/rgmii_rx_clk_en_gen_if.sv
// RGMII receive bundle: IDDR-side GMII inputs, client byte stream outputs and in-band status.
// master = capture/client side, slave = rgmii_rx_clk_en_gen.
interface rgmii_rx_clk_en_gen_if;
  logic [7:0] gmii_rxd_in;
  logic       gmii_rx_dv_in;
  logic       gmii_rx_er_in;
  logic [7:0] client_rxd;
  logic       client_rx_dv;
  logic       client_rx_er;
  logic       client_rxc_en;
  logic       link_status;
  logic [1:0] clock_speed;
  logic       duplex_status;

  modport master (
    output gmii_rxd_in, gmii_rx_dv_in, gmii_rx_er_in,
    input  client_rxd, client_rx_dv, client_rx_er, client_rxc_en,
    input  link_status, clock_speed, duplex_status
  );

  modport slave (
    input  gmii_rxd_in, gmii_rx_dv_in, gmii_rx_er_in,
    output client_rxd, client_rx_dv, client_rx_er, client_rxc_en,
    output link_status, clock_speed, duplex_status
  );
endinterface

// File: rtl/rgmii_rx_clk_en_gen.sv
// RGMII rx clock-enable generator: 1G byte pass-through, 10/100 nibble-to-byte assembly.
// Define RGMII_RX_INBAND_STATUS_EN to build the in-band link/speed/duplex decoder.
module rgmii_rx_clk_en_gen #(
  parameter int SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  speed_10_100,
  input logic                  speed_100,
  rgmii_rx_clk_en_gen_if.slave rx
);

  typedef enum logic [1:0] {
    SPD_10  = 2'b00,
    SPD_100 = 2'b01,
    SPD_1G  = 2'b10
  } speed_e;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

  logic [SYNC_STAGES-1:0] sync_10_100;
  logic [SYNC_STAGES-1:0] sync_100;
  speed_e                 speed_synced;
  speed_e                 active, active_next;
  phase_e                 phase, phase_eff, phase_next;
  logic [3:0]             shadow, shadow_next;
  logic                   shadow_er, shadow_er_next;
  logic                   prev_dv, dv_rise;
  logic [7:0]             rxd_d, rxd_q;
  logic                   dv_d, dv_q, er_d, er_q, en_d, en_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_10_100 <= '0;
      sync_100    <= '0;
    end else begin
      sync_10_100 <= {sync_10_100[SYNC_STAGES-2:0], speed_10_100};
      sync_100    <= {sync_100[SYNC_STAGES-2:0], speed_100};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active    <= SPD_1G;
      phase     <= PH_LOW;
      shadow    <= '0;
      shadow_er <= 1'b0;
      prev_dv   <= 1'b0;
      rxd_q     <= '0;
      dv_q      <= 1'b0;
      er_q      <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      active    <= active_next;
      phase     <= phase_next;
      shadow    <= shadow_next;
      shadow_er <= shadow_er_next;
      prev_dv   <= rx.gmii_rx_dv_in;
      rxd_q     <= rxd_d;
      dv_q      <= dv_d;
      er_q      <= er_d;
      en_q      <= en_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    speed_synced   = SPD_1G;
    dv_rise        = rx.gmii_rx_dv_in && !prev_dv;
    phase_eff      = dv_rise ? PH_LOW : phase;
    phase_next     = (phase_eff == PH_LOW) ? PH_HIGH : PH_LOW;
    shadow_next    = shadow;
    shadow_er_next = shadow_er;
    active_next    = active;
    rxd_d          = '0;
    dv_d           = 1'b0;
    er_d           = 1'b0;
    en_d           = 1'b0;

    if (sync_10_100[SYNC_STAGES-1]) begin
      speed_synced = sync_100[SYNC_STAGES-1] ? SPD_100 : SPD_10;
    end

    if (active == SPD_1G) begin
      rxd_d = rx.gmii_rxd_in;
      dv_d  = rx.gmii_rx_dv_in;
      er_d  = rx.gmii_rx_er_in;
      en_d  = 1'b1;
    end else if (phase_eff == PH_LOW) begin
      shadow_next    = rx.gmii_rxd_in[3:0];
      shadow_er_next = rx.gmii_rx_er_in;
    end else begin
      en_d = 1'b1;
      if (rx.gmii_rx_dv_in) begin
        rxd_d = {rx.gmii_rxd_in[3:0], shadow};
        dv_d  = 1'b1;
        er_d  = rx.gmii_rx_er_in | shadow_er;
      end else if (prev_dv) begin
        // Frame ended after a lone low nibble: flush it as an errored byte.
        rxd_d = {4'h0, shadow};
        dv_d  = 1'b1;
        er_d  = 1'b1;
      end else begin
        er_d  = rx.gmii_rx_er_in | shadow_er;
      end
    end

    // Speed is only switched between frames; a switch realigns the nibble phase.
    if (!rx.gmii_rx_dv_in && (speed_synced != active)) begin
      active_next    = speed_synced;
      phase_next     = PH_LOW;
      shadow_next    = '0;
      shadow_er_next = 1'b0;
    end
  end

  assign rx.client_rxd    = rxd_q;
  assign rx.client_rx_dv  = dv_q;
  assign rx.client_rx_er  = er_q;
  assign rx.client_rxc_en = en_q;

`ifdef RGMII_RX_INBAND_STATUS_EN
  logic       status_ok, prev_ok;
  logic [3:0] prev_nib;
  logic       link_q, duplex_q;
  logic [1:0] speed_q;

  assign status_ok = !rx.gmii_rx_dv_in && !rx.gmii_rx_er_in &&
                     (rx.gmii_rxd_in[3:0] == rx.gmii_rxd_in[7:4]);

  // Status is accepted only after two identical idle samples in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ok  <= 1'b0;
      prev_nib <= '0;
      link_q   <= 1'b0;
      speed_q  <= '0;
      duplex_q <= 1'b0;
    end else begin
      prev_ok  <= status_ok;
      prev_nib <= rx.gmii_rxd_in[3:0];
      if (status_ok && prev_ok && (rx.gmii_rxd_in[3:0] == prev_nib)) begin
        link_q   <= rx.gmii_rxd_in[0];
        speed_q  <= rx.gmii_rxd_in[2:1];
        duplex_q <= rx.gmii_rxd_in[3];
      end
    end
  end

  assign rx.link_status   = link_q;
  assign rx.clock_speed   = speed_q;
  assign rx.duplex_status = duplex_q;
`else
  assign rx.link_status   = 1'b0;
  assign rx.clock_speed   = 2'b00;
  assign rx.duplex_status = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_clk_en_gen.sv
// Self-checking bench for rgmii_rx_clk_en_gen: directed test-plan steps plus random traffic
// compared every cycle against a cycle-count/queue reference model.
module tb_rgmii_rx_clk_en_gen;
  localparam int SYNC_STAGES = 2;
  localparam logic [1:0] C_10 = 2'b00, C_100 = 2'b01, C_1G = 2'b10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic speed_10_100 = 1'b0;
  logic speed_100 = 1'b0;

  rgmii_rx_clk_en_gen_if rx_if ();

  rgmii_rx_clk_en_gen #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk          (clk),
    .reset        (reset),
    .speed_10_100 (speed_10_100),
    .speed_100    (speed_100),
    .rx           (rx_if)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  string step_name = "reset";

  // Reference model state
  logic [1:0] m_active;
  logic [1:0] sync_q[$];
  int         m_cnt;
  logic [3:0] m_sh;
  logic       m_sh_er;
  logic       m_prev_dv;
  logic [4:0] m_hist[$];
  logic       m_link, m_dup;
  logic [1:0] m_spd;
  logic [7:0] e_rxd;
  logic       e_dv, e_er, e_en;

  logic [8:0] cap_q[$];
  logic       capture = 1'b0;

  logic [7:0] bytes_frame [5] = '{8'h55, 8'h55, 8'hD5, 8'h01, 8'h02};
  logic [3:0] nibs_100 [10] = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'hD, 4'h1, 4'h0, 4'h2, 4'h0};
  logic [3:0] nibs_odd [3] = '{4'h5, 4'hD, 4'h7};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", step_name, tag, obs, exp);
    end
  endtask

  // Expected outputs one edge after the given inputs, from the behavioural rules.
  task automatic model(input logic [7:0] d, input logic v, input logic e, input logic r);
    logic [1:0] sync_out;
    logic       ok;
    e_rxd = '0; e_dv = 1'b0; e_er = 1'b0; e_en = 1'b0;
    if (r) begin
      m_active = C_1G;
      sync_q.delete();
      for (int i = 0; i < SYNC_STAGES; i++) sync_q.push_back(C_1G);
      m_cnt = 0; m_sh = '0; m_sh_er = 1'b0; m_prev_dv = 1'b0;
      m_hist.delete();
      m_link = 1'b0; m_spd = 2'b00; m_dup = 1'b0;
      return;
    end
    if (m_active == C_1G) begin
      e_rxd = d; e_dv = v; e_er = e; e_en = 1'b1;
    end else begin
      if (v && !m_prev_dv) m_cnt = 0;
      if (m_cnt % 2 == 0) begin
        m_sh = d[3:0]; m_sh_er = e;
      end else begin
        e_en = 1'b1;
        if (v) begin
          e_rxd = {d[3:0], m_sh}; e_dv = 1'b1; e_er = e | m_sh_er;
        end else if (m_prev_dv) begin
          e_rxd = {4'h0, m_sh}; e_dv = 1'b1; e_er = 1'b1;
        end else begin
          e_er = e | m_sh_er;
        end
      end
      m_cnt++;
    end
    sync_out = sync_q.pop_front();
    sync_q.push_back(!speed_10_100 ? C_1G : (speed_100 ? C_100 : C_10));
    if (!v && sync_out != m_active) begin
      m_active = sync_out; m_cnt = 0; m_sh = '0; m_sh_er = 1'b0;
    end
    m_prev_dv = v;
    ok = !v && !e && (d[3:0] == d[7:4]);
    m_hist.push_back({ok, d[3:0]});
    if (m_hist.size() > 2) void'(m_hist.pop_front());
`ifdef RGMII_RX_INBAND_STATUS_EN
    if (m_hist.size() == 2 && m_hist[0][4] && m_hist[1][4] && m_hist[0] == m_hist[1]) begin
      m_link = d[0]; m_spd = d[2:1]; m_dup = d[3];
    end
`endif
  endtask

  task automatic step(input logic [7:0] d, input logic v, input logic e, input logic r);
    rx_if.gmii_rxd_in   = d;
    rx_if.gmii_rx_dv_in = v;
    rx_if.gmii_rx_er_in = e;
    reset               = r;
    model(d, v, e, r);
    @(posedge clk);
    #1;
    check("rxd", rx_if.client_rxd, e_rxd);
    check("dv", 8'(rx_if.client_rx_dv), 8'(e_dv));
    check("er", 8'(rx_if.client_rx_er), 8'(e_er));
    check("en", 8'(rx_if.client_rxc_en), 8'(e_en));
    check("link", 8'(rx_if.link_status), 8'(m_link));
    check("speed", 8'(rx_if.clock_speed), 8'(m_spd));
    check("duplex", 8'(rx_if.duplex_status), 8'(m_dup));
    if (capture && rx_if.client_rxc_en && rx_if.client_rx_dv)
      cap_q.push_back({rx_if.client_rx_er, rx_if.client_rxd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_status(input logic link, input logic [1:0] spd, input logic dup);
`ifdef RGMII_RX_INBAND_STATUS_EN
    check("status_link", 8'(rx_if.link_status), 8'(link));
    check("status_speed", 8'(rx_if.clock_speed), 8'(spd));
    check("status_duplex", 8'(rx_if.duplex_status), 8'(dup));
`else
    check("status_link", 8'(rx_if.link_status), 8'h00);
    check("status_speed", 8'(rx_if.clock_speed), 8'h00);
    check("status_duplex", 8'(rx_if.duplex_status), 8'h00);
`endif
  endtask

  initial begin
    logic dv_r;
    logic [3:0] nib;

    rx_if.gmii_rxd_in   = '0;
    rx_if.gmii_rx_dv_in = 1'b0;
    rx_if.gmii_rx_er_in = 1'b0;

    step_name = "reset";
    for (int i = 0; i < 3; i++) step(8'hA5, 1'b1, 1'b1, 1'b1);

    step_name = "1g_frame";
    idle(3);
    capture = 1'b1; cap_q.delete();
    for (int i = 0; i < 5; i++) step(bytes_frame[i], 1'b1, 1'b0, 1'b0);
    idle(2);
    capture = 1'b0;
    check("1g_count", 8'(cap_q.size()), 8'd5);
    for (int i = 0; i < 5 && i < cap_q.size(); i++) check("1g_byte", cap_q[i][7:0], bytes_frame[i]);

    step_name = "1g_random";
    for (int i = 0; i < 20; i++) step(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    step_name = "100m_frame";
    speed_10_100 = 1'b1; speed_100 = 1'b1;
    idle(SYNC_STAGES + 4);
    capture = 1'b1; cap_q.delete();
    for (int i = 0; i < 10; i++) step({4'hF, nibs_100[i]}, 1'b1, 1'b0, 1'b0);
    idle(6);
    capture = 1'b0;
    check("100m_count", 8'(cap_q.size()), 8'd5);
    for (int i = 0; i < 5 && i < cap_q.size(); i++) check("100m_byte", 8'(cap_q[i]), {1'b0, bytes_frame[i]});

    step_name = "10m_odd";
    speed_100 = 1'b0;
    idle(SYNC_STAGES + 4);
    capture = 1'b1; cap_q.delete();
    for (int i = 0; i < 3; i++) step({4'h0, nibs_odd[i]}, 1'b1, 1'b0, 1'b0);
    idle(6);
    capture = 1'b0;
    check("odd_count", 8'(cap_q.size()), 8'd2);
    if (cap_q.size() == 2) begin
      check("odd_byte0", 8'(cap_q[0]), 8'hD5);
      check("odd_er0", 8'(cap_q[0][8]), 8'h00);
      check("odd_byte1", 8'(cap_q[1]), 8'h07);
      check("odd_er1", 8'(cap_q[1][8]), 8'h01);
    end

    step_name = "10_100_random";
    for (int f = 0; f < 12; f++) begin
      speed_100 = 1'($urandom);
      idle(int'($urandom_range(1, 5)));
      for (int i = 0; i < int'($urandom_range(1, 14)); i++)
        step(8'($urandom), 1'b1, ($urandom_range(0, 7) == 0), 1'b0);
    end
    idle(4);

    step_name = "speed_change_mid_frame";
    speed_10_100 = 1'b1; speed_100 = 1'b1;
    idle(SYNC_STAGES + 4);
    for (int i = 0; i < 14; i++) begin
      if (i == 3) speed_10_100 = 1'b0;
      step(8'($urandom), 1'b1, 1'b0, 1'b0);
    end
    idle(SYNC_STAGES + 4);
    for (int i = 0; i < 4; i++) step(8'($urandom), 1'b1, 1'b0, 1'b0);
    idle(2);

    step_name = "inband_status";
    step(8'hDD, 1'b0, 1'b0, 1'b0);
    step(8'hDD, 1'b0, 1'b0, 1'b0);
    check_status(1'b1, 2'b10, 1'b1);
    step(8'hD5, 1'b0, 1'b0, 1'b0);
    step(8'hD5, 1'b0, 1'b0, 1'b0);
    check_status(1'b1, 2'b10, 1'b1);
    step(8'h33, 1'b0, 1'b0, 1'b0);
    step(8'h44, 1'b0, 1'b0, 1'b0);
    check_status(1'b1, 2'b10, 1'b1);
    step(8'h22, 1'b0, 1'b0, 1'b0);
    step(8'h22, 1'b0, 1'b0, 1'b0);
    check_status(1'b0, 2'b01, 1'b0);

    step_name = "reset_mid_frame";
    speed_10_100 = 1'b1; speed_100 = 1'b1;
    idle(SYNC_STAGES + 4);
    for (int i = 0; i < 5; i++) step(8'h05, 1'b1, 1'b0, 1'b0);
    step(8'h05, 1'b1, 1'b0, 1'b1);
    check("rst_rxd", rx_if.client_rxd, 8'h00);
    check("rst_en", 8'(rx_if.client_rxc_en), 8'h00);
    idle(SYNC_STAGES + 4);
    capture = 1'b1; cap_q.delete();
    for (int i = 0; i < 10; i++) step({4'h0, nibs_100[i]}, 1'b1, 1'b0, 1'b0);
    idle(3);
    capture = 1'b0;
    check("rst_count", 8'(cap_q.size()), 8'd5);
    if (cap_q.size() > 0) check("rst_first", 8'(cap_q[0]), 8'h55);

    step_name = "mixed_random";
    dv_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 0) begin
        speed_10_100 = 1'($urandom);
        speed_100    = 1'($urandom);
      end
      if ($urandom_range(0, 7) == 0) dv_r = ~dv_r;
      nib = 4'($urandom);
      step(($urandom_range(0, 3) == 0) ? {nib, nib} : 8'($urandom), dv_r,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
